player_motion: RTL and testbench
================================

// Module: player_motion
// PURPOSE
//  Upstream of the tracer/renderer. Owns player position (playerX/playerY).
//  Once per frame tick it applies the moveL/R/F/B buttons and checks each axis
//  move against the map, one axis at a time. Map access is shared with the
//  tracer and overlay through a req/gnt handshake. A move into a wall cell, or
//  off the 16x16 map, is rejected per axis, so the player slides along walls.
// PARAMETERS
//  QM         6                   integer bits of fixed-point position (signed)
//  QN         10                  fraction bits; position width W = QM+QN
//  START_X    (2<<QN)             reset value of playerX (raw fixed-point)
//  START_Y    (13<<QN)+(1<<QN-1)  reset value of playerY (cell 13.5)
//  MOVE_STEP  (1<<QN-7)           per-tick displacement (1/128 cell)
// PORTS
//  clk       in   1   system (pixel) clock
//  reset     in   1   asynchronous, active-high
//  tick      in   1   1-cycle pulse at frame start (h==0 && v==0)
//  moveL     in   1   move -X (has priority over moveR)
//  moveR     in   1   move +X
//  moveF     in   1   move -Y (has priority over moveB)
//  moveB     in   1   move +Y
//  map_req   out  1   map lookup request; held until granted
//  map_gnt   in   1   map port granted this cycle; map_val is valid this cycle
//  map_col   out  4   cell column to look up (valid while map_req)
//  map_row   out  4   cell row to look up (valid while map_req)
//  map_val   in   2   combinational map result; nonzero = wall
//  playerX   out  W   current X, signed QM.QN
//  playerY   out  W   current Y, signed QM.QN
//  busy      out  1   high from tick acceptance until DONE completes
//  bump      out  1   1-cycle pulse in DONE if either axis was rejected
//  overrun   out  1   1-cycle pulse when tick arrives while busy
// BEHAVIOUR
//  - Reset (async) values: playerX=START_X, playerY=START_Y, state=IDLE,
//    map_req=0, busy=0, bump=0, overrun=0, map_col=map_row=0.
//  - IDLE: on tick, latch dx = moveL ? -STEP : moveR ? +STEP : 0, and
//    dy = moveF ? -STEP : moveB ? +STEP : 0.
//    If dx==dy==0, stay IDLE (busy stays 0). Otherwise busy=1 and go to CHK_X.
//  - CHK_X: if dx==0, skip to CHK_Y.
//    Else candX = playerX+dx (W-bit wrapping add).
//    If candX integer part is not in 0..15, reject with no lookup; go to CHK_Y.
//    Else assert map_req, col=candX[QN+3:QN], row=playerY[QN+3:QN].
//    On the first cycle with map_gnt: accept (playerX<=candX) iff map_val==0,
//    then go to CHK_Y.
//  - CHK_Y: same as CHK_X for dy, candY=playerY+dy.
//    col uses the already-updated playerX; row=candY[QN+3:QN]. Then go to DONE.
//  - DONE: busy=0, bump=1 for one cycle if any rejection occurred; go to IDLE.
//  - map_req drops the cycle after grant. map_col/row are stable while
//    map_req=1. Waiting for grant is unbounded; no timeout.
//  - Latency with immediate grant: tick at cycle 0 -> CHK_X 1 -> CHK_Y 2 ->
//    DONE 3 (busy low from cycle 4).
//    playerX updates at the cycle-1 edge; playerY at the cycle-2 edge.
//  - tick while busy: ignored; overrun pulses 1 cycle; FSM is unaffected.
//  - tick in the same cycle as DONE: ignored (overrun=1).
//  - Both buttons of one axis held: the priority rule above applies.
//  - Reset mid-lookup: map_req drops immediately; position returns to START.
// TESTING
//  1. Reset -> playerX=0x0800, playerY=0x3600, map_req=0, busy=0.
//  2. Open map, map_gnt tied 1, moveR held 4 ticks -> playerX=0x0800+4*8=0x0820,
//     bump never asserted.
//  3. Player at X=2.99 (0x0BF8 approx.), cell (3,13) is wall, moveR ->
//     map_col=3,row=13 requested; playerX unchanged; bump pulse 1 cycle.
//  4. moveR+moveF, X wall blocked, Y open -> playerX unchanged,
//     playerY -= 8 (slide); bump=1.
//  5. map_gnt held 0 for 50 cycles, then 1 -> map_req/col/row stable for
//     50 cycles; second tick during the wait -> overrun pulse, single update.
//  6. Player at X=0x0004, moveL -> candX integer <0: rejected, no map_req, bump=1.
//     Also: async reset asserted mid-CHK_Y -> outputs back to reset values
//     without a clock edge.

Source files
------------

// File: rtl/player_motion_if.sv
// Map lookup port shared with the tracer/overlay arbiter.
// master: player_motion drives req/col/row and samples gnt/val; slave: arbiter side.
interface player_motion_if;
    logic       map_req;
    logic       map_gnt;
    logic [3:0] map_col;
    logic [3:0] map_row;
    logic [1:0] map_val;

    modport master (
        output map_req,
        output map_col,
        output map_row,
        input  map_gnt,
        input  map_val
    );

    modport slave (
        input  map_req,
        input  map_col,
        input  map_row,
        output map_gnt,
        output map_val
    );
endinterface

// File: rtl/player_motion.sv
// Player position owner: applies move buttons once per frame tick, checking
// each axis against the map (X then Y) so the player slides along walls.
// Ports: clk, reset (async, active-high), tick, moveL/R/F/B buttons,
//   map (player_motion_if.master lookup port), playerX/playerY (signed QM.QN),
//   busy, bump (rejected-move pulse), overrun (tick while busy pulse).
module player_motion #(
    parameter int QM        = 6,
    parameter int QN        = 10,
    parameter int W         = QM + QN,
    parameter int START_X   = (2 << QN),
    parameter int START_Y   = (13 << QN) + (1 << (QN - 1)),
    parameter int MOVE_STEP = (1 << (QN - 7))
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick,
    input  logic                 moveL,
    input  logic                 moveR,
    input  logic                 moveF,
    input  logic                 moveB,
    player_motion_if.master      map,
    output logic [W-1:0]         playerX,
    output logic [W-1:0]         playerY,
    output logic                 busy,
    output logic                 bump,
    output logic                 overrun
);

    typedef enum logic [1:0] {
        IDLE,
        CHK_X,
        CHK_Y,
        DONE
    } state_t;

    localparam logic [W-1:0] STEP_P = W'(MOVE_STEP);
    localparam logic [W-1:0] STEP_N = W'(-MOVE_STEP);

    state_t       state;
    state_t       state_nx;
    logic [W-1:0] dx;
    logic [W-1:0] dy;
    logic         rej;

    logic [W-1:0] cand_x;
    logic [W-1:0] cand_y;
    logic         in_x;
    logic         in_y;
    logic         need_x;
    logic         need_y;
    logic         any_move;

    assign cand_x = playerX + dx;
    assign cand_y = playerY + dy;

    // integer part in 0..15 <=> every bit above the 4-bit cell index is zero
    assign in_x = (cand_x[W-1:QN+4] == '0);
    assign in_y = (cand_y[W-1:QN+4] == '0);

    assign need_x   = (dx != '0) && in_x;
    assign need_y   = (dy != '0) && in_y;
    assign any_move = moveL | moveR | moveF | moveB;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (tick && any_move) begin
                    state_nx = CHK_X;
                end
            end
            CHK_X: begin
                if (!need_x || map.map_gnt) begin
                    state_nx = CHK_Y;
                end
            end
            CHK_Y: begin
                if (!need_y || map.map_gnt) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        map.map_req = 1'b0;
        map.map_col = 4'd0;
        map.map_row = 4'd0;
        busy        = (state != IDLE);
        bump        = 1'b0;
        overrun     = tick && (state != IDLE);
        unique case (state)
            CHK_X: begin
                if (need_x) begin
                    map.map_req = 1'b1;
                    map.map_col = cand_x[QN+3:QN];
                    map.map_row = playerY[QN+3:QN];
                end
            end
            CHK_Y: begin
                // column uses X as already updated by CHK_X
                if (need_y) begin
                    map.map_req = 1'b1;
                    map.map_col = playerX[QN+3:QN];
                    map.map_row = cand_y[QN+3:QN];
                end
            end
            DONE: begin
                bump = rej;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            playerX <= W'(START_X);
            playerY <= W'(START_Y);
            dx      <= '0;
            dy      <= '0;
            rej     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (tick) begin
                        dx  <= moveL ? STEP_N : (moveR ? STEP_P : '0);
                        dy  <= moveF ? STEP_N : (moveB ? STEP_P : '0);
                        rej <= 1'b0;
                    end
                end
                CHK_X: begin
                    if (dx != '0) begin
                        if (!in_x) begin
                            rej <= 1'b1;
                        end else if (map.map_gnt) begin
                            if (map.map_val == 2'd0) begin
                                playerX <= cand_x;
                            end else begin
                                rej <= 1'b1;
                            end
                        end
                    end
                end
                CHK_Y: begin
                    if (dy != '0) begin
                        if (!in_y) begin
                            rej <= 1'b1;
                        end else if (map.map_gnt) begin
                            if (map.map_val == 2'd0) begin
                                playerY <= cand_y;
                            end else begin
                                rej <= 1'b1;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_player_motion.sv
// Self-checking bench for player_motion: vector table, corner sequences,
// and randomized ticks against a whole-move reference model.
module tb_player_motion;

    localparam logic [15:0] SX = 16'h0800;
    localparam logic [15:0] SY = 16'h3600;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        tick = 1'b0;
    logic        moveL = 1'b0;
    logic        moveR = 1'b0;
    logic        moveF = 1'b0;
    logic        moveB = 1'b0;
    logic [15:0] playerX;
    logic [15:0] playerY;
    logic        busy;
    logic        bump;
    logic        overrun;

    player_motion_if mif ();

    bit wall [16][16];
    int gnt_mode = 1;
    int total = 0;
    int bad = 0;

    typedef struct {
        bit wv;
        int wc;
        int wr;
        bit l;
        bit r;
        bit f;
        bit b;
        int edx;
        int edy;
        int ebump;
        int ecyc;
    } vec_t;

    vec_t tv [10];

    always #5 clk = ~clk;

    player_motion dut (
        .clk     (clk),
        .reset   (reset),
        .tick    (tick),
        .moveL   (moveL),
        .moveR   (moveR),
        .moveF   (moveF),
        .moveB   (moveB),
        .map     (mif),
        .playerX (playerX),
        .playerY (playerY),
        .busy    (busy),
        .bump    (bump),
        .overrun (overrun)
    );

    assign mif.map_val = wall[mif.map_col][mif.map_row] ? 2'd3 : 2'd0;

    initial begin
        forever begin
            @(negedge clk);
            case (gnt_mode)
                0:       mif.map_gnt = 1'b0;
                1:       mif.map_gnt = 1'b1;
                default: mif.map_gnt = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic clear_walls();
        for (int c = 0; c < 16; c++)
            for (int r = 0; r < 16; r++)
                wall[c][r] = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 500; i++) begin
            if (!busy) break;
            @(negedge clk);
        end
        check("idle_timeout", 32'(busy), 0);
    endtask

    task automatic run_tick(input bit l, input bit r, input bit f,
                            input bit b, output int bumps, output int cyc,
                            output int reqs, output logic [3:0] col,
                            output logic [3:0] row);
        bumps = 0;
        cyc   = 0;
        reqs  = 0;
        col   = 4'd0;
        row   = 4'd0;
        @(negedge clk);
        tick = 1'b1;
        moveL = l;
        moveR = r;
        moveF = f;
        moveB = b;
        @(negedge clk);
        tick = 1'b0;
        moveL = 1'b0;
        moveR = 1'b0;
        moveF = 1'b0;
        moveB = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (!busy) break;
            cyc++;
            if (bump) bumps++;
            if (mif.map_req) begin
                reqs++;
                col = mif.map_col;
                row = mif.map_row;
            end
            @(negedge clk);
        end
        check("busy_timeout", 32'(busy), 0);
    endtask

    // Whole-move reference: one axis at a time, cell = floor(pos), wall or
    // off-map cell rejects that axis only.
    function automatic void model(input logic [15:0] x, input logic [15:0] y,
                                  input bit l, input bit r, input bit f,
                                  input bit b, output logic [15:0] nx,
                                  output logic [15:0] ny, output int bmp);
        int dx;
        int dy;
        int cx;
        int cy;
        logic [15:0] w;
        dx = l ? -8 : (r ? 8 : 0);
        dy = f ? -8 : (b ? 8 : 0);
        nx = x;
        ny = y;
        bmp = 0;
        if (dx != 0) begin
            w  = x + 16'(dx);
            cx = int'($signed(w)) >>> 10;
            cy = int'($signed(y)) >>> 10;
            if (cx < 0 || cx > 15 || wall[cx][cy]) bmp = 1;
            else nx = w;
        end
        if (dy != 0) begin
            w  = y + 16'(dy);
            cy = int'($signed(w)) >>> 10;
            cx = int'($signed(nx)) >>> 10;
            if (cy < 0 || cy > 15 || wall[cx][cy]) bmp = 1;
            else ny = w;
        end
    endfunction

    initial begin
        int bumps, cyc, reqs, acc;
        logic [3:0] col, row, c0, r0;
        logic [15:0] ex, ey, mx, my;
        int eb, stable;
        logic ov_hit, ov_after;

        tv[0] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tv[1] = '{0, 0, 0, 0, 1, 0, 0, 8, 0, 0, 3};
        tv[2] = '{0, 0, 0, 1, 0, 0, 0, -8, 0, 0, 3};
        tv[3] = '{1, 1, 13, 1, 0, 0, 0, 0, 0, 1, 3};
        tv[4] = '{0, 0, 0, 1, 1, 0, 0, -8, 0, 0, 3};
        tv[5] = '{0, 0, 0, 0, 0, 1, 1, 0, -8, 0, 3};
        tv[6] = '{1, 2, 13, 0, 1, 1, 0, 0, 0, 1, 3};
        tv[7] = '{1, 1, 13, 1, 0, 1, 0, 0, -8, 1, 3};
        tv[8] = '{1, 2, 13, 0, 0, 0, 1, 0, 0, 1, 3};
        tv[9] = '{1, 3, 13, 0, 1, 0, 0, 8, 0, 0, 3};

        clear_walls();
        @(negedge clk);
        @(negedge clk);
        check("rst_x", 32'(playerX), 32'(SX));
        check("rst_y", 32'(playerY), 32'(SY));
        check("rst_req", 32'(mif.map_req), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_bump", 32'(bump), 0);
        check("rst_ovr", 32'(overrun), 0);
        check("rst_col", 32'({mif.map_col, mif.map_row}), 0);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            do_reset();
            clear_walls();
            gnt_mode = 1;
            if (tv[i].wv) wall[tv[i].wc][tv[i].wr] = 1'b1;
            run_tick(tv[i].l, tv[i].r, tv[i].f, tv[i].b,
                     bumps, cyc, reqs, col, row);
            ex = SX + 16'(tv[i].edx);
            ey = SY + 16'(tv[i].edy);
            check($sformatf("vec%0d_x", i), 32'(playerX), 32'(ex));
            check($sformatf("vec%0d_y", i), 32'(playerY), 32'(ey));
            check($sformatf("vec%0d_bump", i), bumps, tv[i].ebump);
            check($sformatf("vec%0d_cyc", i), cyc, tv[i].ecyc);
        end

        do_reset();
        clear_walls();
        acc = 0;
        for (int i = 0; i < 4; i++) begin
            run_tick(0, 1, 0, 0, bumps, cyc, reqs, col, row);
            acc += bumps;
        end
        check("open4_x", 32'(playerX), 32'h0820);
        check("open4_bump", acc, 0);

        do_reset();
        clear_walls();
        for (int i = 0; i < 127; i++)
            run_tick(0, 1, 0, 0, bumps, cyc, reqs, col, row);
        check("edge_x", 32'(playerX), 32'h0BF8);
        wall[3][13] = 1'b1;
        run_tick(0, 1, 0, 0, bumps, cyc, reqs, col, row);
        check("wall_col", 32'(col), 3);
        check("wall_row", 32'(row), 13);
        check("wall_x", 32'(playerX), 32'h0BF8);
        check("wall_bump", bumps, 1);
        check("wall_bump_end", 32'(bump), 0);

        do_reset();
        clear_walls();
        gnt_mode = 0;
        @(negedge clk);
        @(negedge clk);
        tick = 1'b1;
        moveR = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        moveR = 1'b0;
        c0 = mif.map_col;
        r0 = mif.map_row;
        stable = 0;
        ov_hit = 1'b0;
        ov_after = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (mif.map_req === 1'b1 && mif.map_col == c0 &&
                mif.map_row == r0) stable++;
            if (i == 20) begin
                tick = 1'b1;
                moveL = 1'b1;
                #1 ov_hit = overrun;
            end
            @(negedge clk);
            if (i == 20) begin
                tick = 1'b0;
                moveL = 1'b0;
                #1 ov_after = overrun;
            end
        end
        check("wait_stable", stable, 50);
        check("wait_col", 32'(c0), 2);
        check("wait_row", 32'(r0), 13);
        check("ovr_pulse", 32'(ov_hit), 1);
        check("ovr_clear", 32'(ov_after), 0);
        gnt_mode = 1;
        wait_idle();
        repeat (5) @(negedge clk);
        check("wait_x", 32'(playerX), 32'h0808);
        check("wait_y", 32'(playerY), 32'(SY));
        check("wait_busy", 32'(busy), 0);

        do_reset();
        clear_walls();
        for (int i = 0; i < 256; i++)
            run_tick(1, 0, 0, 0, bumps, cyc, reqs, col, row);
        check("left_x0", 32'(playerX), 0);
        run_tick(1, 0, 0, 0, bumps, cyc, reqs, col, row);
        check("left_noreq", reqs, 0);
        check("left_bump", bumps, 1);
        check("left_x", 32'(playerX), 0);

        do_reset();
        clear_walls();
        run_tick(0, 1, 0, 0, bumps, cyc, reqs, col, row);
        check("ar_pre_x", 32'(playerX), 32'h0808);
        gnt_mode = 0;
        @(negedge clk);
        @(negedge clk);
        tick = 1'b1;
        moveF = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        moveF = 1'b0;
        @(negedge clk);
        check("ar_pre_req", 32'(mif.map_req), 1);
        #2 reset = 1'b1;
        #1;
        check("ar_req", 32'(mif.map_req), 0);
        check("ar_busy", 32'(busy), 0);
        check("ar_x", 32'(playerX), 32'(SX));
        check("ar_y", 32'(playerY), 32'(SY));
        check("ar_colrow", 32'({mif.map_col, mif.map_row}), 0);
        @(negedge clk);
        reset = 1'b0;

        gnt_mode = 2;
        for (int k = 0; k < 4; k++) begin
            do_reset();
            for (int c = 0; c < 16; c++)
                for (int r = 0; r < 16; r++)
                    wall[c][r] = ($urandom_range(0, 5) == 0);
            wall[2][13] = 1'b0;
            wall[1][13] = 1'($urandom_range(0, 1));
            mx = SX;
            my = SY;
            for (int i = 0; i < 75; i++) begin
                bit l, r, f, b;
                l = 1'($urandom_range(0, 1));
                r = 1'($urandom_range(0, 1));
                f = 1'($urandom_range(0, 1));
                b = 1'($urandom_range(0, 1));
                model(mx, my, l, r, f, b, ex, ey, eb);
                run_tick(l, r, f, b, bumps, cyc, reqs, col, row);
                check("rnd_x", 32'(playerX), 32'(ex));
                check("rnd_y", 32'(playerY), 32'(ey));
                check("rnd_bump", bumps, eb);
                mx = ex;
                my = ey;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
